cam_gray_capture: RTL

- Camera-side write stage for the 320x240 8-bit grayscale frame buffer, clocked by the camera pixel clock.
- Receives the OV7670 RGB565 byte stream (vsync/href/8-bit data) and pairs bytes into pixels.
- Converts each pixel to 8-bit luma and drives the frame buffer write port (we, wAddr, wData) with a linear raster address.
- Provides frame-boundary alignment, per-frame error flagging and a frame-done strobe for the stereo control logic.

---
 rtl/cam_gray_capture_pkg.sv | 18 +
 rtl/cam_gray_capture_rgb565_to_gray.sv | 25 ++
 rtl/cam_gray_capture.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cam_gray_capture_pkg.sv
// Shared constants and types for the camera-side grayscale capture path.
package cam_gray_capture_pkg;

  localparam int H_RES        = 320;
  localparam int V_RES        = 240;
  localparam int FRAME_PIXELS = H_RES * V_RES;
  localparam int ADDR_W       = 17;

  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    CAPTURE   = 1'b1
  } cap_state_t;

endpackage

// File: rtl/cam_gray_capture_rgb565_to_gray.sv
// Combinational RGB565 to 8-bit luma converter, shared by every colour-to-gray path.
module rgb565_to_gray
  import cam_gray_capture_pkg::*;
(
  input  logic [15:0] rgb,
  output logic [7:0]  gray
);

  // Channels are widened by bit replication so full scale maps to 255; the
  // coefficients sum to 256, so the 16-bit sum cannot overflow.
  function automatic logic [7:0] luma(input logic [15:0] w);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {w[15:11], w[15:13]};
    g8  = {w[10:5], w[10:9]};
    b8  = {w[4:0], w[4:2]};
    sum = LUMA_R * {8'd0, r8} + LUMA_G * {8'd0, g8} + LUMA_B * {8'd0, b8};
    return sum[15:8];
  endfunction

  assign gray = luma(rgb);

endmodule

// File: rtl/cam_gray_capture.sv
// OV7670 RGB565 byte stream to grayscale frame-buffer writes, with frame
// alignment, sticky per-frame error flag and frame-done strobe.
module cam_gray_capture #(
  parameter int H_RES  = cam_gray_capture_pkg::H_RES,
  parameter int V_RES  = cam_gray_capture_pkg::V_RES,
  parameter int ADDR_W = cam_gray_capture_pkg::ADDR_W
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [7:0]        wData,
  output logic              frame_done,
  output logic              frame_err
);
  import cam_gray_capture_pkg::*;

  localparam int FRAME_SIZE = H_RES * V_RES;
  // One spare bit so the pixel count can reach FRAME_SIZE even if it equals 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam int X_W   = $clog2(H_RES + 2);
  localparam int Y_W   = $clog2(V_RES + 2);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_SIZE);
  localparam logic [X_W-1:0]   X_LINE    = X_W'(H_RES);
  localparam logic [Y_W-1:0]   Y_LINES   = Y_W'(V_RES);

  cap_state_t        state_q, state_d;
  logic              vsync_dly_q, href_dly_q;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              vs_fall, vs_rise, hr_fall;
  logic [7:0]        gray;

  assign vs_fall = vsync_dly_q & ~cam_vsync;
  assign vs_rise = ~vsync_dly_q & cam_vsync;
  assign hr_fall = href_dly_q & ~cam_href;

  rgb565_to_gray u_gray (
    .rgb  ({hi_q, cam_data}),
    .gray (gray)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      WAIT_SYNC: begin
        if (vs_fall && capture_en) begin
          state_d = CAPTURE;
          phase_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (vs_fall) begin
          // Frame start without a closing vsync rise: abandon and realign.
          phase_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (!capture_en) state_d = WAIT_SYNC;
        end else begin
          if (cam_href) begin
            if (!phase_q) begin
              hi_d    = cam_data;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (cnt_q == FRAME_CNT || y_q >= Y_LINES) begin
                err_d = 1'b1;
              end else begin
                we_d    = 1'b1;
                wdata_d = gray;
                waddr_d = cnt_q[ADDR_W-1:0];
                cnt_d   = cnt_q + CNT_W'(1);
              end
              if (x_q != '1) x_d = x_q + X_W'(1);
            end
          end
          if (hr_fall) begin
            if (x_q != X_LINE) err_d = 1'b1;
            phase_d = 1'b0;
            x_d     = '0;
            if (y_q != '1) y_d = y_q + Y_W'(1);
          end
          if (vs_rise) begin
            done_d  = 1'b1;
            if (cnt_q != FRAME_CNT) err_d = 1'b1;
            state_d = WAIT_SYNC;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  // ---- register stage: control state and write port ----
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q     <= WAIT_SYNC;
      vsync_dly_q <= 1'b0;
      href_dly_q  <= 1'b0;
      phase_q     <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_dly_q <= cam_vsync;
      href_dly_q  <= cam_href;
      phase_q     <= phase_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge pclk) begin
    hi_q <= hi_d;
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
